sc_reg_matrix_bank: RTL
=======================

// Module: sc_reg_matrix_bank
// PURPOSE
//  Multi-row successor of the single-row matrix register: DEPTH rows of DATAWIDTH bits.
//  Supports per-row load, shift and rotate, plus full-row detection.
//  Adds a multi-cycle "collapse" operation that deletes every full row and drops the rows
//  above it. Sits between the game datapath mux and the LED-matrix display scanner.
// PARAMETERS
//  RegBANK_DATAWIDTH   8          bits per row
//  RegBANK_DEPTH       8          number of rows (row 0 = bottom, DEPTH-1 = top)
//  RegBANK_ADDRWIDTH   3          address width, >= clog2(DEPTH)
//  DATA_FIXED_INITROW  8'h00      row value used by clear and for rows injected at the top
// PORTS
//  SC_RegBANK_CLOCK_50        in   1        system clock
//  SC_RegBANK_RESET_InHigh    in   1        reset, asynchronous, active-high
//  SC_RegBANK_clear_InLow     in   1        sync clear of all rows to INITROW
//  SC_RegBANK_load_InLow      in   1        write data_InBUS to row addr_In
//  SC_RegBANK_shift_In        in   2        row op on row addr_In: 00 hold, 01 shl, 10 shr, 11 rotl
//  SC_RegBANK_addr_In         in   AW       write/shift row address
//  SC_RegBANK_data_InBUS      in   DW       write data
//  SC_RegBANK_collapse_InLow  in   1        start collapse (sampled in IDLE only)
//  SC_RegBANK_rdaddr_In       in   AW       read row address
//  SC_RegBANK_data_OutBUS     out  DW       row[rdaddr_In], combinational from registers
//  SC_RegBANK_fullrow_Out     out  DEPTH    bit i = row i is all ones, combinational
//  SC_RegBANK_busy_Out        out  1        collapse in progress
//  SC_RegBANK_done_Out        out  1        one-cycle pulse when collapse completes
//  SC_RegBANK_removed_Out     out  AW+1     number of rows removed by the last collapse
// BEHAVIOUR
//  Reset: all rows 0 (not INITROW); FSM IDLE; busy, done and removed are 0.
//  Priority each cycle: clear > collapse FSM activity > load > shift.
//  - clear: all rows become INITROW; FSM forced to IDLE with no done pulse; removed becomes 0.
//  - load/shift: apply only when busy=0; load wins over shift in the same cycle.
//    - shl  = {row[DW-2:0],0}
//    - shr  = {0,row[DW-1:1]}
//    - rotl = {row[DW-2:0],row[DW-1]}
//  - addr_In >= DEPTH: write and shift are ignored. rdaddr_In >= DEPTH: read returns 0.
//  Collapse FSM states: IDLE -> SCAN -> DONE -> IDLE.
//  - IDLE: collapse_InLow=0 -> SCAN next cycle. Any load/shift in that same cycle lands
//    first, so the scan sees the updated rows. Pointer p=0, remaining R=DEPTH, removed=0.
//  - SCAN (busy=1), one step per cycle, R decrements every step:
//    - row[p] full: rows p..DEPTH-2 take the row above; row DEPTH-1 takes INITROW;
//      removed++; p holds.
//    - row[p] not full: p++.
//    - R reaching 0 -> DONE. SCAN therefore lasts exactly DEPTH cycles, and each original
//      row is examined once (this terminates even when INITROW is all ones).
//  - DONE: busy=0, done=1 for one cycle -> IDLE. removed holds until the next start or clear.
//  - While busy: collapse_InLow, load and shift are ignored; reads and fullrow stay live.
//  - Async reset mid-collapse: immediate return to reset state.
//  Latency: start sampled at edge N; busy=1 for edges N+1..N+DEPTH; done=1 after edge N+DEPTH+1.
// STRUCTURE
//  sc_regbank_pkg: FSM state localparams (IDLE/SCAN/DONE), shift-mode codes (HOLD/SHL/SHR/ROTL).
//  Sub-module sc_regbank_collapse_ctrl:
//  - holds the FSM, the p and R counters, and the removed counter;
//  - drives busy/done and a per-cycle "collapse at p" strobe into the row array kept in the top.
// TESTING (DW=8, DEPTH=8, INITROW=00)
//  1. Reset -> data_Out=00, fullrow=00, busy=0, removed=0. Load row3=A5, rdaddr=3 -> A5 next cycle.
//  2. row2=81: shift 01 -> 02; reload 81, shift 11 -> 03; reload 81, shift 10 -> 40.
//     Load+shift together on row2 with data 55 -> 55.
//  3. Rows0..4 = FF,0F,FF,FF,3C, rest 00; collapse -> busy 8 cycles, done pulse;
//     rows0=0F, row1=3C, rest 00; removed=3; fullrow=00.
//  4. Only row7=FF -> after collapse row7=00, removed=1. With INITROW=FF and all rows FF,
//     busy stays exactly 8 cycles; removed=8.
//  5. Clear asserted on 3rd SCAN cycle -> all rows 00, busy=0 next cycle, no done pulse, removed=0.
//  6. During busy: load row0=AA and collapse re-request -> both ignored.
//     Async reset mid-SCAN -> all outputs 0 immediately.

Source files
------------

// File: rtl/sc_regbank_pkg.sv
// Shared types for the multi-row matrix register bank.
// Collapse FSM states and per-row shift-mode codes.
package sc_regbank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } cstate_e;

    typedef enum logic [1:0] {
        SH_HOLD = 2'b00,
        SH_SHL  = 2'b01,
        SH_SHR  = 2'b10,
        SH_ROTL = 2'b11
    } shift_e;

endpackage

// File: rtl/sc_regbank_collapse_ctrl.sv
// Collapse sequencer: walks the rows once, strobing a delete at the
// pointer whenever that row is full, and counts the rows removed.
module sc_regbank_collapse_ctrl
    import sc_regbank_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [DEPTH-1:0] fullrow_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             collapse_o,
    output logic [AW:0]      ptr_o,
    output logic [AW:0]      removed_o
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    cstate_e     state_q, state_d;
    logic [AW:0] ptr_q, ptr_d;
    logic [AW:0] left_q, left_d;
    logic [AW:0] removed_q, removed_d;
    logic        full_at_p;

    always_comb begin
        full_at_p = 1'b0;
        if (ptr_q < DEPTH_W) full_at_p = fullrow_i[ptr_q[AW-1:0]];
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        left_d     = left_q;
        removed_d  = removed_q;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        collapse_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_SCAN;
                    ptr_d     = '0;
                    left_d    = DEPTH_W;
                    removed_d = '0;
                end
            end
            ST_SCAN: begin
                busy_o = 1'b1;
                left_d = left_q - 1'b1;
                // A deleted row pulls the next one down into p, so p holds
                if (full_at_p) begin
                    collapse_o = 1'b1;
                    removed_d  = removed_q + 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
                if (left_q == (AW+1)'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear_i) begin
            state_d    = ST_IDLE;
            removed_d  = '0;
            collapse_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            left_q    <= '0;
            removed_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            left_q    <= left_d;
            removed_q <= removed_d;
        end
    end

    assign ptr_o     = ptr_q;
    assign removed_o = removed_q;

endmodule

// File: rtl/sc_reg_matrix_bank.sv
// Row array for the LED matrix: per-row load/shift/rotate, full-row
// flags, and the collapse that deletes full rows under sequencer control.
module sc_reg_matrix_bank
    import sc_regbank_pkg::*;
#(
    parameter int RegBANK_DATAWIDTH = 8,
    parameter int RegBANK_DEPTH     = 8,
    parameter int RegBANK_ADDRWIDTH = 3,
    parameter logic [RegBANK_DATAWIDTH-1:0] DATA_FIXED_INITROW = '0
) (
    input  logic                         SC_RegBANK_CLOCK_50,
    input  logic                         SC_RegBANK_RESET_InHigh,
    input  logic                         SC_RegBANK_clear_InLow,
    input  logic                         SC_RegBANK_load_InLow,
    input  logic [1:0]                   SC_RegBANK_shift_In,
    input  logic [RegBANK_ADDRWIDTH-1:0] SC_RegBANK_addr_In,
    input  logic [RegBANK_DATAWIDTH-1:0] SC_RegBANK_data_InBUS,
    input  logic                         SC_RegBANK_collapse_InLow,
    input  logic [RegBANK_ADDRWIDTH-1:0] SC_RegBANK_rdaddr_In,
    output logic [RegBANK_DATAWIDTH-1:0] SC_RegBANK_data_OutBUS,
    output logic [RegBANK_DEPTH-1:0]     SC_RegBANK_fullrow_Out,
    output logic                         SC_RegBANK_busy_Out,
    output logic                         SC_RegBANK_done_Out,
    output logic [RegBANK_ADDRWIDTH:0]   SC_RegBANK_removed_Out
);

    localparam int DW    = RegBANK_DATAWIDTH;
    localparam int DEPTH = RegBANK_DEPTH;
    localparam int AW    = RegBANK_ADDRWIDTH;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DW-1:0] rows_q [DEPTH];
    logic [DW-1:0] rows_d [DEPTH];
    logic          busy;
    logic          collapse;
    logic [AW:0]   ptr;
    logic          wr_ok;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) SC_RegBANK_fullrow_Out[i] = &rows_q[i];
    end

    always_comb begin
        SC_RegBANK_data_OutBUS = '0;
        if ({1'b0, SC_RegBANK_rdaddr_In} < DEPTH_W)
            SC_RegBANK_data_OutBUS = rows_q[SC_RegBANK_rdaddr_In];
    end

    assign wr_ok = ({1'b0, SC_RegBANK_addr_In} < DEPTH_W);

    sc_regbank_collapse_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ctrl (
        .clk_i      (SC_RegBANK_CLOCK_50),
        .rst_i      (SC_RegBANK_RESET_InHigh),
        .clear_i    (~SC_RegBANK_clear_InLow),
        .start_i    (~SC_RegBANK_collapse_InLow),
        .fullrow_i  (SC_RegBANK_fullrow_Out),
        .busy_o     (busy),
        .done_o     (SC_RegBANK_done_Out),
        .collapse_o (collapse),
        .ptr_o      (ptr),
        .removed_o  (SC_RegBANK_removed_Out)
    );

    assign SC_RegBANK_busy_Out = busy;

    always_comb begin
        rows_d = rows_q;
        if (!SC_RegBANK_clear_InLow) begin
            for (int i = 0; i < DEPTH; i++) rows_d[i] = DATA_FIXED_INITROW;
        end else if (collapse) begin
            for (int i = 0; i < DEPTH - 1; i++)
                if (i >= int'(ptr)) rows_d[i] = rows_q[i+1];
            rows_d[DEPTH-1] = DATA_FIXED_INITROW;
        end else if (!busy && wr_ok) begin
            if (!SC_RegBANK_load_InLow) begin
                rows_d[SC_RegBANK_addr_In] = SC_RegBANK_data_InBUS;
            end else begin
                unique case (shift_e'(SC_RegBANK_shift_In))
                    SH_HOLD: ;
                    SH_SHL: rows_d[SC_RegBANK_addr_In] =
                        {rows_q[SC_RegBANK_addr_In][DW-2:0], 1'b0};
                    SH_SHR: rows_d[SC_RegBANK_addr_In] =
                        {1'b0, rows_q[SC_RegBANK_addr_In][DW-1:1]};
                    SH_ROTL: rows_d[SC_RegBANK_addr_In] =
                        {rows_q[SC_RegBANK_addr_In][DW-2:0],
                         rows_q[SC_RegBANK_addr_In][DW-1]};
                endcase
            end
        end
    end

    always_ff @(posedge SC_RegBANK_CLOCK_50 or posedge SC_RegBANK_RESET_InHigh) begin
        if (SC_RegBANK_RESET_InHigh) begin
            for (int i = 0; i < DEPTH; i++) rows_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) rows_q[i] <= rows_d[i];
        end
    end

endmodule
